// File: rtl/strb_ram_rd_streamer_pkg.sv
// Shared definitions for the strobed-RAM read streamer.
//   state_e     : burst sequencer states
//   rd_latency  : RAM port B read latency from the output-register setting
package strb_ram_rd_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int unsigned rd_latency(input bit oreg_en);
        return oreg_en ? 32'd2 : 32'd1;
    endfunction

endpackage

// File: rtl/strb_ram_rd_fifo.sv
// First-word-fall-through FIFO holding {last, data} beats between the RAM read
// pipeline and the output stream.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (flushes contents)
//   push_i      : write wdata_i this cycle
//   wdata_i     : entry to write
//   pop_i       : consume the head entry (ignored when empty)
//   valid_o     : head entry present
//   rdata_o     : head entry, stable until popped
//   count_o     : number of stored entries (pre-pop value this cycle)
module strb_ram_rd_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    // Upstream credit accounting keeps pushes away from a full FIFO; the guard
    // only protects contents if that invariant is ever broken.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/strb_ram_rd_streamer.sv
// Read-side streamer for the nibble-strobed buffer RAM. Accepts one burst
// command at a time, issues port B reads under a credit check so that every
// outstanding read has a FIFO slot, and emits the words as a valid/ready stream
// with a last flag.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/ready/addr/len : burst command (len = beats - 1)
//   ram_*_b                  : RAM port B (read-only, output reg always enabled)
//   m_valid/ready/data/last  : output stream
//   busy                     : burst in progress until its last beat is taken
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a command
// ST_ISSUE | issuing reads while credit allows
// ST_DRAIN | all reads issued, waiting for the last beat to be popped
module strb_ram_rd_streamer
    import strb_ram_rd_streamer_pkg::*;
#(
    parameter int    AWIDTH     = 12,
    parameter int    DWIDTH     = 128,
    parameter string OREG_B     = "TRUE",
    parameter int    LEN_W      = 8,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              ram_en_b,
    output logic              ram_we_b,
    output logic              ram_rst_b,
    output logic [AWIDTH-1:0] ram_addr_b,
    output logic              ram_oreg_ce_b,
    input  logic [DWIDTH-1:0] ram_rd_data_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              busy
);
    localparam int LAT = int'(rd_latency(OREG_B == "TRUE"));
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int SW  = CW + 1;

    state_e             state_q, state_d;
    logic [AWIDTH-1:0]  addr_q,  addr_d;
    logic [LEN_W-1:0]   rem_q,   rem_d;
    logic               busy_q,  busy_d;
    logic [LAT-1:0]     sr_vld_q,  sr_vld_d;
    logic [LAT-1:0]     sr_last_q, sr_last_d;

    logic [SW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic               credit_ok, issue, issue_last;
    logic               fifo_valid, fifo_last, pop;
    logic [DWIDTH:0]    fifo_rdata;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + SW'(sr_vld_q[i]);
    end

    // Pre-pop count: a slot freed this cycle is not reused until next cycle.
    assign credit_ok  = (inflight + SW'(fifo_count)) < SW'(FIFO_DEPTH);
    assign issue      = (state_q == ST_ISSUE) && credit_ok;
    assign issue_last = issue && (rem_q == '0);
    assign pop        = fifo_valid && m_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_last) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage i holds the read issued i+1 cycles ago; the oldest stage lines up
    // with the RAM data for that read.
    always_comb begin
        sr_vld_d     = sr_vld_q;
        sr_last_d    = sr_last_q;
        sr_vld_d[0]  = issue;
        sr_last_d[0] = issue_last;
        for (int i = 1; i < LAT; i++) begin
            sr_vld_d[i]  = sr_vld_q[i-1];
            sr_last_d[i] = sr_last_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            sr_vld_q  <= '0;
            sr_last_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            sr_vld_q  <= sr_vld_d;
            sr_last_q <= sr_last_d;
        end
    end

    strb_ram_rd_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sr_vld_q[LAT-1]),
        .wdata_i ({sr_last_q[LAT-1], ram_rd_data_b}),
        .pop_i   (m_ready),
        .valid_o (fifo_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign fifo_last     = fifo_rdata[DWIDTH];
    assign cmd_ready     = (state_q == ST_IDLE) && !rst;
    assign ram_en_b      = issue;
    assign ram_we_b      = 1'b0;
    assign ram_rst_b     = rst;
    assign ram_addr_b    = addr_q;
    assign ram_oreg_ce_b = 1'b1;
    assign m_valid       = fifo_valid;
    assign m_data        = fifo_rdata[DWIDTH-1:0];
    assign m_last        = fifo_valid && fifo_last;
    assign busy          = busy_q;

endmodule

// File: tb/tb_strb_ram_rd_streamer.sv
module tb_strb_ram_rd_streamer;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, cmd_valid, m_ready;
    logic [11:0]  cmd_addr;
    logic [7:0]   cmd_len;

    logic         c_rdy0, en0, we0, rrst0, oce0, mv0, ml0, busy0;
    logic [11:0]  addr0;
    logic [127:0] rd0, md0;
    logic         c_rdy1, en1, we1, rrst1, oce1, mv1, ml1, busy1;
    logic [11:0]  addr1;
    logic [127:0] rd1, md1;

    strb_ram_rd_streamer #(.OREG_B("TRUE")) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(c_rdy0),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_en_b(en0), .ram_we_b(we0),
        .ram_rst_b(rrst0), .ram_addr_b(addr0), .ram_oreg_ce_b(oce0),
        .ram_rd_data_b(rd0), .m_valid(mv0), .m_ready(m_ready), .m_data(md0),
        .m_last(ml0), .busy(busy0));

    strb_ram_rd_streamer #(.OREG_B("FALSE")) u_dut_noreg (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(c_rdy1),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_en_b(en1), .ram_we_b(we1),
        .ram_rst_b(rrst1), .ram_addr_b(addr1), .ram_oreg_ce_b(oce1),
        .ram_rd_data_b(rd1), .m_valid(mv1), .m_ready(m_ready), .m_data(md1),
        .m_last(ml1), .busy(busy1));

    // RAM model: one array, a two-stage pipe for the registered-output port
    // and a one-stage pipe for the unregistered one.
    logic [127:0] mem [4096];
    logic [127:0] p0a, p0b, p1a;
    always @(posedge clk) begin
        if (en0) p0a <= mem[addr0];
        p0b <= p0a;
        if (en1) p1a <= mem[addr1];
    end
    assign rd0 = p0b;
    assign rd1 = p1a;

    int           sel = 0;
    logic         o_rdy, o_en, o_we, o_rrst, o_oce, o_valid, o_last, o_busy;
    logic [11:0]  o_addr;
    logic [127:0] o_data;
    always_comb begin
        if (sel == 0) begin
            {o_rdy, o_en, o_we, o_rrst, o_oce, o_valid, o_last, o_busy} =
                {c_rdy0, en0, we0, rrst0, oce0, mv0, ml0, busy0};
            o_addr = addr0;
            o_data = md0;
        end else begin
            {o_rdy, o_en, o_we, o_rrst, o_oce, o_valid, o_last, o_busy} =
                {c_rdy1, en1, we1, rrst1, oce1, mv1, ml1, busy1};
            o_addr = addr1;
            o_data = md1;
        end
    end

    beat_t       exp_q[$];
    beat_t       got_q[$];
    int          got_cyc[$];
    logic [11:0] iss_q[$];
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    // Start on the negedge, hold cmd_valid until accepted, return 1 ns after the
    // accepting edge. Expected beats are pushed on acceptance.
    task automatic send_cmd(input logic [11:0] a, input logic [7:0] l, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 50; i++) begin
            if (o_rdy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            for (int i = 0; i <= int'(l); i++)
                exp_q.push_back(beat_t'{mem[12'(int'(a) + i)], (i == int'(l))});
        end
        #1 cmd_valid = 1'b0;
    endtask

    // Observe the stream for up to budget cycles (cycle 1 = first cycle after
    // acceptance). mode 0: always ready; mode 1: ready on odd cycles only.
    task automatic collect(input int mode, input int stop_after, input int budget,
                           output int first_cyc, output int nbeat,
                           output int credit_bad, output int hold_bad);
        int issued, popped;
        bit prev_stall, done;
        beat_t prev;
        issued = 0; popped = 0; prev_stall = 0; done = 0;
        first_cyc = -1; nbeat = 0; credit_bad = 0; hold_bad = 0;
        prev = beat_t'{'0, 1'b0};
        for (int cyc = 1; cyc <= budget && !done; cyc++) begin
            @(negedge clk);
            m_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
            if (o_en) begin
                if (issued - popped >= 4) credit_bad++;
                issued++;
                iss_q.push_back(o_addr);
            end
            if (prev_stall && (!o_valid || o_data !== prev.data || o_last !== prev.last))
                hold_bad++;
            if (o_valid && first_cyc < 0) first_cyc = cyc;
            if (o_valid && m_ready) begin
                got_q.push_back(beat_t'{o_data, o_last});
                got_cyc.push_back(cyc);
                popped++;
                nbeat++;
                if (o_last || nbeat == stop_after) done = 1;
            end
            prev_stall = o_valid && !m_ready;
            prev = beat_t'{o_data, o_last};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_clear();
        m_ready = 1'b1;
        repeat (12) @(negedge clk);
        exp_q.delete(); got_q.delete(); got_cyc.delete(); iss_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (o_rdy !== 1'b0) $display("FAIL reset_cmd_ready got %b exp 0", o_rdy); else pass_cnt++;
        chk_cnt++; if (o_rrst !== 1'b1) $display("FAIL ram_rst_b_in_reset got %b exp 1", o_rrst); else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++; if (o_en !== 1'b0) $display("FAIL reset_ram_en got %b exp 0", o_en); else pass_cnt++;
        chk_cnt++; if (o_addr !== 12'h0) $display("FAIL reset_ram_addr got %h exp 0", o_addr); else pass_cnt++;
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_m_valid got %b exp 0", o_valid); else pass_cnt++;
        chk_cnt++; if (o_last !== 1'b0) $display("FAIL reset_m_last got %b exp 0", o_last); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", o_busy); else pass_cnt++;
        chk_cnt++; if (o_we !== 1'b0 || o_oce !== 1'b1 || o_rrst !== 1'b0)
            $display("FAIL ram_ties got we=%b oce=%b rst=%b exp 0 1 0", o_we, o_oce, o_rrst); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (o_rdy !== 1'b1) $display("FAIL post_reset_cmd_ready got %b exp 1", o_rdy); else pass_cnt++;
    endtask

    // Shared by the two timing-checked full-rate bursts (registered / not).
    task automatic test_burst_timing(input int exp_first, input string tag);
        bit ok; int fc, nb, cb, hb; beat_t e, g;
        drain_and_clear();
        send_cmd(12'h010, 8'd3, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL %s_accept got %b exp 1", tag, ok); else pass_cnt++;
        collect(0, 0, 40, fc, nb, cb, hb);
        chk_cnt++; if (fc != exp_first) $display("FAIL %s_first_valid_cycle got %0d exp %0d", tag, fc, exp_first); else pass_cnt++;
        chk_cnt++; if (nb != 4) $display("FAIL %s_beats got %0d exp 4", tag, nb); else pass_cnt++;
        for (int k = 0; k < got_cyc.size(); k++) begin
            chk_cnt++; if (got_cyc[k] != exp_first + k) $display("FAIL %s_beat%0d_cycle got %0d exp %0d", tag, k, got_cyc[k], exp_first + k); else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (got_q.size() == 0) $display("FAIL %s_missing_beat got none exp %h", tag, e.data);
            else begin
                g = got_q.pop_front();
                if (g.data !== e.data || g.last !== e.last)
                    $display("FAIL %s_beat got %h/%b exp %h/%b", tag, g.data, g.last, e.data, e.last);
                else pass_cnt++;
            end
        end
        chk_cnt++; if (got_q.size() != 0) $display("FAIL %s_extra_beats got %0d exp 0", tag, got_q.size()); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL %s_busy_after_last got %b exp 0", tag, o_busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok; int fc, nb, cb, hb; beat_t e, g;
        drain_and_clear();
        send_cmd(12'h010, 8'd3, ok);
        #1;
        chk_cnt++; if (o_busy !== 1'b1) $display("FAIL bp_busy_during got %b exp 1", o_busy); else pass_cnt++;
        collect(1, 0, 60, fc, nb, cb, hb);
        chk_cnt++; if (nb != 4) $display("FAIL bp_beats got %0d exp 4", nb); else pass_cnt++;
        chk_cnt++; if (cb != 0) $display("FAIL bp_credit_violations got %0d exp 0", cb); else pass_cnt++;
        chk_cnt++; if (hb != 0) $display("FAIL bp_hold_violations got %0d exp 0", hb); else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (got_q.size() == 0) $display("FAIL bp_missing_beat got none exp %h", e.data);
            else begin
                g = got_q.pop_front();
                if (g.data !== e.data || g.last !== e.last)
                    $display("FAIL bp_beat got %h/%b exp %h/%b", g.data, g.last, e.data, e.last);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_wrap();
        bit ok; int fc, nb, cb, hb; beat_t e, g; logic [11:0] ea;
        drain_and_clear();
        send_cmd(12'hFFE, 8'd3, ok);
        collect(0, 0, 40, fc, nb, cb, hb);
        chk_cnt++; if (iss_q.size() != 4) $display("FAIL wrap_issue_count got %0d exp 4", iss_q.size()); else pass_cnt++;
        for (int k = 0; k < 4 && k < iss_q.size(); k++) begin
            ea = 12'hFFE + 12'(k);
            chk_cnt++; if (iss_q[k] !== ea) $display("FAIL wrap_addr%0d got %h exp %h", k, iss_q[k], ea); else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (got_q.size() == 0) $display("FAIL wrap_missing_beat got none exp %h", e.data);
            else begin
                g = got_q.pop_front();
                if (g.data !== e.data || g.last !== e.last)
                    $display("FAIL wrap_beat got %h/%b exp %h/%b", g.data, g.last, e.data, e.last);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_single();
        bit ok; int fc, nb, cb, hb; beat_t e, g;
        drain_and_clear();
        send_cmd(12'h055, 8'd0, ok);
        collect(0, 0, 30, fc, nb, cb, hb);
        chk_cnt++; if (nb != 1) $display("FAIL single_beats got %0d exp 1", nb); else pass_cnt++;
        e = exp_q.pop_front();
        chk_cnt++;
        if (got_q.size() == 0) $display("FAIL single_missing_beat got none exp %h", e.data);
        else begin
            g = got_q.pop_front();
            if (g.data !== e.data || g.last !== 1'b1)
                $display("FAIL single_beat got %h/%b exp %h/1", g.data, g.last, e.data);
            else pass_cnt++;
        end
        chk_cnt++; if (o_rdy !== 1'b1) $display("FAIL single_cmd_ready_after got %b exp 1", o_rdy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        bit ok; int fc, nb, cb, hb, stale; beat_t e, g;
        drain_and_clear();
        send_cmd(12'h020, 8'd7, ok);
        collect(0, 2, 30, fc, nb, cb, hb);
        chk_cnt++; if (nb != 2) $display("FAIL rst_pre_beats got %0d exp 2", nb); else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++; if (o_rdy !== 1'b0) $display("FAIL rst_mid_cmd_ready got %b exp 0", o_rdy); else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_mid_m_valid got %b exp 0", o_valid); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", o_busy); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (got_q.size() == 0) $display("FAIL rst_pre_missing got none exp %h", e.data);
            else begin
                g = got_q.pop_front();
                if (g.data !== e.data || g.last !== e.last)
                    $display("FAIL rst_pre_beat got %h/%b exp %h/%b", g.data, g.last, e.data, e.last);
                else pass_cnt++;
            end
        end
        exp_q.delete();
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid) stale++;
        end
        chk_cnt++; if (stale != 0) $display("FAIL rst_stale_beats got %0d exp 0", stale); else pass_cnt++;
        got_q.delete(); iss_q.delete();
        send_cmd(12'h030, 8'd1, ok);
        collect(0, 0, 30, fc, nb, cb, hb);
        chk_cnt++; if (nb != 2) $display("FAIL rst_post_beats got %0d exp 2", nb); else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (got_q.size() == 0) $display("FAIL rst_post_missing got none exp %h", e.data);
            else begin
                g = got_q.pop_front();
                if (g.data !== e.data || g.last !== e.last)
                    $display("FAIL rst_post_beat got %h/%b exp %h/%b", g.data, g.last, e.data, e.last);
                else pass_cnt++;
            end
        end
        repeat (4) @(negedge clk);
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_post_extra got %b exp 0", o_valid); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[16 + i] = 128'hA0 + 128'(i);
        sel = 0;
        test_reset();
        test_burst_timing(4, "oreg");
        test_backpressure();
        test_wrap();
        test_single();
        test_reset_mid_burst();
        sel = 1;
        test_burst_timing(3, "noreg");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
